// File: rtl/bus_fifo_pkg.sv
// Shared packet types and helpers for the per-device bus FIFOs, drivers, monitors and scoreboard.
// Optional statistics counters in bus_dev_fifo are enabled with FIFO_STATS_EN.
package bus_fifo_pkg;

    localparam int PCKG_SZ = 16;
    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    typedef logic [PCKG_SZ-1:0] pkt_t;

    function automatic logic [7:0] dest_of(input pkt_t pkt);
        return pkt[PCKG_SZ-1 -: 8];
    endfunction

    // Statistics counters hold at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_dev_fifo_chk.sv
// Protocol checker for bus_dev_fifo strobes; bound or instantiated alongside each FIFO.
module bus_dev_fifo_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic pop
);

    a_strobes_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(push) && !$isunknown(pop))
        else $error("bus_dev_fifo_chk: X on push/pop");

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device show-ahead FIFO between a device driver and one bus slot.
// Define FIFO_STATS_EN to add saturating push/pop/drop counters.
module bus_dev_fifo
    import bus_fifo_pkg::*;
#(
    parameter int pckg_sz = PCKG_SZ,
    parameter int depth   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       pop,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic                       overflow,
    output logic                       underflow
`ifdef FIFO_STATS_EN
    ,
    output logic [31:0]                push_cnt,
    output logic [31:0]                pop_cnt,
    output logic [31:0]                drop_cnt
`endif
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [pckg_sz-1:0] mem_q [depth];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic               drop;

    assign empty = (count_q == {CW{1'b0}});

    // Accept/reject decisions; a pop while full frees the slot the same-edge push needs.
    always_comb begin
        wr_en       = push && (!full || pop);
        rd_en       = pop && !empty;
        drop        = push && full && !pop;
        overflow_d  = drop;
        underflow_d = pop && empty;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and error-pulse state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; empty gating on D_pop hides stale words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= D_push;
        end
    end

    assign D_pop     = empty ? {pckg_sz{1'b0}} : mem_q[rd_ptr_q];
    assign pndng     = !empty;
    assign full      = (count_q == CW'(depth));
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_STATS_EN
    logic [31:0] push_cnt_q, push_cnt_d;
    logic [31:0] pop_cnt_q,  pop_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Next values of the saturating statistics counters.
    always_comb begin
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_en) begin
            push_cnt_d = sat_inc(push_cnt_q);
        end else begin
            push_cnt_d = push_cnt_q;
        end
        if (rd_en) begin
            pop_cnt_d = sat_inc(pop_cnt_q);
        end else begin
            pop_cnt_d = pop_cnt_q;
        end
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_cnt_q <= 32'd0;
            pop_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed self-checking bench for bus_dev_fifo (depth 8, 16-bit packets).
module tb_bus_dev_fifo;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        pop;
    logic [15:0] D_pop;
    logic        pndng;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
`ifdef FIFO_STATS_EN
    logic [31:0] push_cnt;
    logic [31:0] pop_cnt;
    logic [31:0] drop_cnt;
`endif

    int n_cmp;
    int n_err;

    bus_dev_fifo #(.pckg_sz(16), .depth(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .D_push    (D_push),
        .pop       (pop),
        .D_pop     (D_pop),
        .pndng     (pndng),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FIFO_STATS_EN
        ,
        .push_cnt  (push_cnt),
        .pop_cnt   (pop_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    bus_dev_fifo_chk chk (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        D_push = 16'h0000;
        tick();
        tick();
        check("rst_pndng", {31'd0, pndng}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_dpop", {16'd0, D_pop}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_unf", {31'd0, underflow}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single push/pop, no bypass
        push = 1'b1; D_push = 16'h0A11;
        #1;
        check("t1_nobypass", {16'd0, D_pop}, 32'd0);
        tick(); idle();
        check("t1_pndng", {31'd0, pndng}, 32'd1);
        check("t1_dpop", {16'd0, D_pop}, 32'h0A11);
        check("t1_count", {28'd0, count}, 32'd1);
        pop = 1'b1;
        tick(); idle();
        check("t1_pndng0", {31'd0, pndng}, 32'd0);
        check("t1_dpop0", {16'd0, D_pop}, 32'd0);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; D_push = 16'h0100 + 16'(i);
            tick();
        end
        idle();
        check("t2_full", {31'd0, full}, 32'd1);
        check("t2_count", {28'd0, count}, 32'd8);
        push = 1'b1; D_push = 16'hDEAD;
        tick(); idle();
        check("t2_ovf", {31'd0, overflow}, 32'd1);
        check("t2_count_ovf", {28'd0, count}, 32'd8);
        tick();
        check("t2_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t2_order", {16'd0, D_pop}, 32'h0100 + i);
            pop = 1'b1;
            tick();
        end
        idle();
        check("t2_empty", {28'd0, count}, 32'd0);
        check("t2_pndng", {31'd0, pndng}, 32'd0);

        // 3: push&pop while full
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            tick();
        end
        push = 1'b1; pop = 1'b1; D_push = 16'hBEEF;
        tick(); idle();
        check("t3_count", {28'd0, count}, 32'd8);
        check("t3_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            check("t3_order", {16'd0, D_pop}, 32'h0200 + i);
            pop = 1'b1;
            tick();
        end
        check("t3_beef", {16'd0, D_pop}, 32'hBEEF);
        tick(); idle();
        check("t3_empty", {28'd0, count}, 32'd0);

        // 4: underflow cases
        pop = 1'b1;
        tick(); idle();
        check("t4_unf", {31'd0, underflow}, 32'd1);
        check("t4_count", {28'd0, count}, 32'd0);
        tick();
        check("t4_unf_clr", {31'd0, underflow}, 32'd0);
        push = 1'b1; pop = 1'b1; D_push = 16'h0042;
        tick(); idle();
        check("t4_po_unf", {31'd0, underflow}, 32'd1);
        check("t4_po_count", {28'd0, count}, 32'd1);
        check("t4_po_dpop", {16'd0, D_pop}, 32'h0042);
        pop = 1'b1;
        tick(); idle();
        check("t4_drain", {28'd0, count}, 32'd0);

        // 5: streaming with pointer wrap
        push = 1'b1; D_push = 16'h0300;
        tick();
        for (int i = 1; i < 20; i++) begin
            push = 1'b1; pop = 1'b1; D_push = 16'h0300 + 16'(i);
            check("t5_order", {16'd0, D_pop}, 32'h0300 + i - 1);
            tick();
            check("t5_count", {28'd0, count}, 32'd1);
        end
        idle();
        check("t5_last", {16'd0, D_pop}, 32'h0313);
        pop = 1'b1;
        tick(); idle();
        check("t5_empty", {28'd0, count}, 32'd0);

        // 6: reset mid-stream
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; D_push = 16'h0400 + 16'(i);
            tick();
        end
        idle();
        check("t6_loaded", {28'd0, count}, 32'd5);
        #2 reset = 1'b1;
        #1;
        check("t6_async_pndng", {31'd0, pndng}, 32'd0);
        check("t6_async_count", {28'd0, count}, 32'd0);
        tick();
        #2 reset = 1'b0;
        tick();
        push = 1'b1; D_push = 16'h0F0F;
        tick(); idle();
        check("t6_first", {16'd0, D_pop}, 32'h0F0F);
        check("t6_count", {28'd0, count}, 32'd1);
`ifdef FIFO_STATS_EN
        check("t6_push_cnt", push_cnt, 32'd1);
        check("t6_drop_cnt", drop_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
